// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RISC-V style instruction encoder that loads words into instruction memory
//
// Purpose: accepts decoded instruction fields in a start/finish load session. It encodes
// each legal beat into a 32-bit instruction word and writes that word to sequential
// instruction-memory addresses. Illegal beats are consumed and counted.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, finish         session control pulses
//   in_valid / in_ready   field handshake
//   fmt, opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   mem_we, mem_addr, mem_wdata                      instruction-memory write port
//   busy, full            session state (LOAD / FULL)
//   count                 words written this session
//   err_cnt               rejected beats this session, saturating
module instr_encoder #(
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          finish,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    fmt,
   input  logic [4:0]    opcode,
   input  logic [2:0]    funct3,
   input  logic [6:0]    funct7,
   input  logic [4:0]    rd,
   input  logic [4:0]    rs1,
   input  logic [4:0]    rs2,
   input  logic [31:0]   imm,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          busy,
   output logic          full,
   output logic [AW:0]   count,
   output logic [7:0]    err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   count_q;
   logic [7:0]    err_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;

   logic          accept;
   logic          legal;
   logic          last_word;
   logic          is_shift;
   logic          fits12, fits13, fits21, shamt_ok;
   logic [31:0]   enc;
   logic [6:0]    low;

   // Immediate range checks: the value must equal the sign extension of its low bits.
   assign fits12   = (imm[31:11] == {21{imm[11]}});
   assign fits13   = (imm[31:12] == {20{imm[12]}});
   assign fits21   = (imm[31:20] == {12{imm[20]}});
   assign shamt_ok = (imm[31:5] == 27'd0);
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      legal = 1'b0;
      case (fmt)
         3'd0:    legal = 1'b1;
         3'd1:    legal = is_shift ? shamt_ok : fits12;
         3'd2:    legal = fits12;
         3'd3:    legal = fits13 && !imm[0];
         3'd4:    legal = (imm[11:0] == 12'd0);
         3'd5:    legal = fits21 && !imm[0];
         default: legal = 1'b0;
      endcase
   end

   assign low = {opcode, 2'b11};

   always_comb begin
      enc = {25'd0, low};
      case (fmt)
         3'd0: enc = {funct7, rs2, rs1, funct3, rd, low};
         3'd1: enc = is_shift ? {funct7, imm[4:0], rs1, funct3, rd, low}
                              : {imm[11:0], rs1, funct3, rd, low};
         3'd2: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], low};
         3'd3: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], low};
         3'd4: enc = {imm[31:12], rd, low};
         3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, low};
         default: enc = {25'd0, low};
      endcase
   end

   // Session control pulses block the handshake so a beat never races a restart.
   assign in_ready  = rst_n && (state_q == ST_LOAD) && !start && !finish;
   assign accept    = in_valid && in_ready;
   assign last_word = (count_q + 1'b1) == (AW+1)'(DEPTH);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start)
         state_d = ST_LOAD;
      else if (finish)
         state_d = ST_IDLE;
      else if (accept && legal && last_word)
         state_d = ST_FULL;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= 8'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
      end else begin
         we_q <= accept && legal;
         if (accept && legal) begin
            addr_q  <= count_q[AW-1:0];
            wdata_q <= enc;
         end
         if (start) begin
            count_q <= '0;
            err_q   <= 8'd0;
         end else if (accept) begin
            if (legal)
               count_q <= count_q + 1'b1;
            else if (err_q != 8'hFF)
               err_q <= err_q + 8'd1;
         end
      end
   end

   // The strobe is masked while reset is held so a write registered just before
   // reset is dropped rather than reaching memory.
   assign mem_we    = we_q && rst_n;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q == ST_LOAD);
   assign full      = (state_q == ST_FULL);
   assign count     = count_q;
   assign err_cnt   = err_q;

endmodule
